branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences branch resolution in the 5-stage pipeline.
- Consumes the EX-stage branch comparator result (branch_taken) and compares it against the fetch-time prediction.
- On mispredict: raises a registered redirect to IF with a valid/ready handshake, pulses IF/ID flushes, and holds EX until fetch accepts.
- Owns the branch prediction table read by IF and keeps branch/mispredict statistics.

Parameters:
ADDR_WIDTH, 32, PC width in bits
BHT_ENTRIES, 64, number of 2-bit counters; power of 2, index = pc[log2(BHT_ENTRIES)+1:2]
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX stage holds a valid instruction
ex_is_branch  input  1  EX instruction is a conditional branch
ex_is_jump  input  1  EX instruction is jal/jalr (always taken)
ex_pc  input  ADDR_WIDTH  PC of EX instruction
ex_target  input  ADDR_WIDTH  computed taken target
ex_pred_taken  input  1  prediction carried down from IF
branch_taken  input  1  comparator result for EX branch
if_pred_pc  input  ADDR_WIDTH  PC being fetched
if_pred_taken  output  1  prediction for if_pred_pc
redirect_valid  output  1  redirect request to IF
redirect_pc  output  ADDR_WIDTH  corrected fetch PC
if_ready  input  1  IF accepts redirect this cycle
flush_if  output  1  kill IF/ID register contents
flush_id  output  1  kill ID/EX register contents
stall_ex  output  1  hold EX stage
stat_branches  output  CNT_WIDTH  resolved conditional branches
stat_mispredicts  output  CNT_WIDTH  mispredicted branches + jumps

Behaviour:
- Reset (async, rst_n=0): state=IDLE; redirect_valid=0; redirect_pc=0; flush_if=flush_id=0; stats=0; all BHT counters=2'b01 (weakly not-taken).
- stall_ex = (state==WAIT_ACK), combinational from state.
- actual = ex_is_jump ? 1 : branch_taken.
- Resolve event: ex_valid & (ex_is_branch | ex_is_jump) & state==IDLE.
- Mispredict = resolve event & (actual != ex_pred_taken).
- Correct PC = actual ? ex_target : ex_pc+4. Addition is modulo 2^ADDR_WIDTH, so wrap-around is allowed.
- FSM IDLE: a mispredict at edge T gives, from T+1: redirect_valid=1, redirect_pc=correct PC, flush_if=flush_id=1 for exactly one cycle, state=WAIT_ACK. A resolve with no mispredict leaves outputs unchanged.
- FSM WAIT_ACK: redirect_valid and redirect_pc held stable. At an edge with if_ready=1: redirect_valid=0 next cycle, state=IDLE. All EX inputs are ignored in this state, including resolve events, BHT updates and stats.
- if_ready high in the first WAIT_ACK cycle gives a one-cycle redirect.
- if_ready while redirect_valid=0 is ignored.
- BHT update: on a resolve event with ex_is_branch, the counter at the ex_pc index saturates up if taken and down if not taken (00..11). Jumps do not update the BHT.
- if_pred_taken = counter[if_pred_pc index][1], combinational read of the pre-edge value. A same-index read and write in one cycle returns the old value.
- Stats: stat_branches increments on every resolve event with ex_is_branch. stat_mispredicts increments on every mispredict. Both saturate at all-ones, with no wrap.
- ex_is_branch and ex_is_jump both set: treated as a jump.
- Reset mid-WAIT_ACK: redirect is dropped immediately (async).

Optional Feature:
- Macro BRANCH_BHT_EN.
- Defined: BHT behaves as above.
- Undefined: no counter storage; if_pred_taken is constant 0 (static not-taken); BHT updates are removed. Mispredict, FSM and stats logic are unchanged.

Test Plan:
- Reset, then branch at ex_pc=0x80000000, branch_taken=1, ex_pred_taken=0, target=0x80000100 -> T+1: redirect_valid=1, redirect_pc=0x80000100, flush_if=flush_id=1 for one cycle, stall_ex=1; stat_mispredicts=1.
- Hold if_ready=0 for 3 cycles, then 1 -> redirect_valid and redirect_pc stable for 4 cycles; redirect_valid=0 and stall_ex=0 the cycle after acceptance; EX resolve events during the wait leave the stats unchanged.
- Predicted not-taken, branch_taken=0 at ex_pc=0x80000010 -> no redirect; stat_branches increments; counter at that index goes 01->00.
- Same PC resolved taken twice (with BRANCH_BHT_EN) -> counter goes 01->10->11; if_pred_taken=1 for if_pred_pc=0x80000000; without the macro it stays 0.
- jal at ex_pc=0xFFFFFFFC with ex_pred_taken=1 -> no redirect, BHT unchanged. Same jal with ex_pred_taken=0 -> redirect_pc=ex_target.
- Not-taken mispredict at ex_pc=0xFFFFFFFC (pred=1, actual=0) -> redirect_pc=0x00000000 (wrap). Assert rst_n=0 during WAIT_ACK -> redirect_valid=0 immediately.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage branch resolution, fetch redirect handshake, BHT and stats
// Define BRANCH_BHT_EN to enable the 2-bit counter BHT; otherwise IF predicts static not-taken.
module branch_redirect_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] if_pred_pc,
  output logic                  if_pred_taken,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  if_ready,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic                  stall_ex,
  output logic [CNT_WIDTH-1:0]  stat_branches,
  output logic [CNT_WIDTH-1:0]  stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                state, state_next;
  logic                  flush_q;
  logic [ADDR_WIDTH-1:0] redirect_pc_q;
  logic [CNT_WIDTH-1:0]  branches_q, mispredicts_q;
  logic                  actual, resolve, branch_resolve, mispredict;
  logic [ADDR_WIDTH-1:0] correct_pc;

  // A branch+jump combination is resolved as a jump: no BHT update, not a branch stat.
  always_comb begin
    actual         = ex_is_jump ? 1'b1 : branch_taken;
    resolve        = ex_valid & (ex_is_branch | ex_is_jump) & (state == IDLE);
    branch_resolve = resolve & ex_is_branch & ~ex_is_jump;
    mispredict     = resolve & (actual != ex_pred_taken);
    correct_pc     = actual ? ex_target : ex_pc + ADDR_WIDTH'(4);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (mispredict) state_next = WAIT_ACK;
      WAIT_ACK: if (if_ready)   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) redirect_pc_q <= correct_pc;
      if (branch_resolve && branches_q != '1) branches_q <= branches_q + CNT_WIDTH'(1);
      if (mispredict && mispredicts_q != '1) mispredicts_q <= mispredicts_q + CNT_WIDTH'(1);
    end
  end

  // Redirect lives exactly as long as WAIT_ACK, so an async reset drops it at once.
  assign redirect_valid   = (state == WAIT_ACK);
  assign stall_ex         = (state == WAIT_ACK);
  assign redirect_pc      = redirect_pc_q;
  assign flush_if         = flush_q;
  assign flush_id         = flush_q;
  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

`ifdef BRANCH_BHT_EN
  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             unused_pc_bits;

  assign wr_idx = ex_pc[IDX_W+1:2];
  assign rd_idx = if_pred_pc[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (branch_resolve) begin
      if (branch_taken && bht[wr_idx] != 2'b11)
        bht[wr_idx] <= bht[wr_idx] + 2'b01;
      else if (!branch_taken && bht[wr_idx] != 2'b00)
        bht[wr_idx] <= bht[wr_idx] - 2'b01;
    end
  end

  assign if_pred_taken  = bht[rd_idx][1];
  assign unused_pc_bits = ^{if_pred_pc[ADDR_WIDTH-1:IDX_W+2], if_pred_pc[1:0]};
`else
  logic unused_pc_bits;

  assign if_pred_taken  = 1'b0;
  assign unused_pc_bits = ^if_pred_pc;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
// Honours BRANCH_BHT_EN for the expected fetch prediction.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken, branch_taken;
  logic [31:0] ex_pc, ex_target, if_pred_pc;
  logic        if_pred_taken, redirect_valid, if_ready, flush_if, flush_id, stall_ex;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

  branch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .branch_taken(branch_taken), .if_pred_pc(if_pred_pc),
    .if_pred_taken(if_pred_taken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_ready(if_ready), .flush_if(flush_if), .flush_id(flush_id), .stall_ex(stall_ex),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, br, jmp, pred, taken;
    logic [31:0] pc, target;
    logic        exp_redir;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        redir;
    logic [31:0] pc;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  logic [1:0]  mbht[64];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned exp_br = 0;
  int unsigned exp_mp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_BHT_EN
    return mbht[pc[7:2]][1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one EX instruction for one edge in IDLE and score the cycle after it.
  task automatic apply_vec(input vec_t v, input logic rdy);
    exp_t e;
    ex_valid      = v.valid;
    ex_is_branch  = v.br;
    ex_is_jump    = v.jmp;
    ex_pc         = v.pc;
    ex_target     = v.target;
    ex_pred_taken = v.pred;
    branch_taken  = v.taken;
    if_pred_pc    = v.pc;
    if_ready      = rdy;
    #1;
    check("pred_before_update", {31'd0, if_pred_taken}, {31'd0, model_pred(v.pc)});
    sb.push_back('{redir: v.exp_redir, pc: v.exp_pc});
    if (v.valid && v.br && !v.jmp) begin
      exp_br++;
      if (v.taken && mbht[v.pc[7:2]] != 2'b11) mbht[v.pc[7:2]] = mbht[v.pc[7:2]] + 2'b01;
      else if (!v.taken && mbht[v.pc[7:2]] != 2'b00) mbht[v.pc[7:2]] = mbht[v.pc[7:2]] - 2'b01;
    end
    if (v.exp_redir) exp_mp++;
    tick();
    ex_valid = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.redir});
      if (e.redir) check("redirect_pc", redirect_pc, e.pc);
      check("flush_if", {31'd0, flush_if}, {31'd0, e.redir});
      check("flush_id", {31'd0, flush_id}, {31'd0, e.redir});
      check("stall_ex", {31'd0, stall_ex}, {31'd0, e.redir});
    end
    check("stat_branches", stat_branches, exp_br);
    check("stat_mispredicts", stat_mispredicts, exp_mp);
  endtask

  initial begin
    //            valid br   jmp  pred taken pc            target        redir pc
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h8000_0200, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0100, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 32'h0000_1000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0020, 32'h8000_0300, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0024, 32'h8000_0400, 1'b1, 32'h8000_0400};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0024, 32'h8000_0400, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_567C};
    for (int i = 0; i < 64; i++) mbht[i] = 2'b01;

    rst_n = 1'b0;  ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; branch_taken = 1'b0;
    if_pred_pc = 32'h8000_0000; if_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_flush_if", {31'd0, flush_if}, 32'd0);
    check("rst_flush_id", {31'd0, flush_id}, 32'd0);
    check("rst_stall_ex", {31'd0, stall_ex}, 32'd0);
    check("rst_stat_branches", stat_branches, 32'd0);
    check("rst_stat_mispredicts", stat_mispredicts, 32'd0);
    check("rst_if_pred_taken", {31'd0, if_pred_taken}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Taken mispredict, fetch stalls the ack for three cycles while EX keeps resolving.
    apply_vec('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0100, 1'b1, 32'h8000_0100}, 1'b0);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jump = 1'b0;
    ex_pc = 32'h8000_0040; ex_target = 32'h8000_0800; ex_pred_taken = 1'b1; branch_taken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wait_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      check("wait_redirect_pc", redirect_pc, 32'h8000_0100);
      check("wait_flush_if", {31'd0, flush_if}, 32'd0);
      check("wait_stall_ex", {31'd0, stall_ex}, 32'd1);
    end
    if_ready = 1'b1;
    tick();
    ex_valid = 1'b0; if_ready = 1'b0;
    check("ack_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("ack_stall_ex", {31'd0, stall_ex}, 32'd0);
    check("wait_stat_branches", stat_branches, exp_br);
    check("wait_stat_mispredicts", stat_mispredicts, exp_mp);

    // Table vectors; if_ready is high in the resolve cycle (ignored) and the one after (ack).
    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i], 1'b1);
      if (vecs[i].exp_redir) begin
        tick();
        check("one_cycle_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("one_cycle_stall_ex", {31'd0, stall_ex}, 32'd0);
      end
      if_ready = 1'b0;
    end

    if_pred_pc = 32'h8000_0000;
    #1;
    check("pred_after_two_taken", {31'd0, if_pred_taken}, {31'd0, model_pred(32'h8000_0000)});
`ifdef BRANCH_BHT_EN
    check("pred_taken_enabled", {31'd0, if_pred_taken}, 32'd1);
`else
    check("pred_static_not_taken", {31'd0, if_pred_taken}, 32'd0);
`endif
    if_pred_pc = 32'h8000_0040;
    #1;
    check("pred_no_update_in_wait", {31'd0, if_pred_taken}, {31'd0, model_pred(32'h8000_0040)});
    @(negedge clk);

    // Not-taken mispredict at the top of the address space wraps, then reset mid-wait.
    apply_vec('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 32'h0000_0000}, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("async_rst_stall_ex", {31'd0, stall_ex}, 32'd0);
    check("async_rst_stat_mispredicts", stat_mispredicts, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
